// File: rtl/sw_conditioner.sv
// Push-switch front end: 2-flop synchroniser, counter debounce and
// press / release / long-press / auto-repeat pulse generation per channel.
module sw_conditioner #(
    parameter int NUM_SW        = 4,
    parameter int DEB_CYCLES    = 500000,
    parameter int LONG_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_SW-1:0] i_sw,
    output logic [NUM_SW-1:0] o_level,
    output logic [NUM_SW-1:0] o_press,
    output logic [NUM_SW-1:0] o_release,
    output logic [NUM_SW-1:0] o_long,
    output logic [NUM_SW-1:0] o_step
);

    localparam logic        RAW_IDLE = (ACTIVE_LOW != 0);
    localparam logic [31:0] DEB_LAST = 32'(DEB_CYCLES - 1);
    localparam logic [31:0] LONG_LAST = 32'(LONG_CYCLES - 1);
    localparam logic [31:0] REP_LAST = 32'(REPEAT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        HELD,
        LONG,
        DEB_REL
    } state_t;

    logic [NUM_SW-1:0] r_sync1;
    logic [NUM_SW-1:0] r_sync2;
    logic [NUM_SW-1:0] w_pressed;

    // Synchronisers idle at the released raw level so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= {NUM_SW{RAW_IDLE}};
            r_sync2 <= {NUM_SW{RAW_IDLE}};
        end else begin
            // NOTE: non-blocking assignments make the two flops a real 2-stage delay.
            r_sync1 <= i_sw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pressed = r_sync2 ^ {NUM_SW{RAW_IDLE}};

    for (genvar g = 0; g < NUM_SW; g++) begin : g_ch
        state_t      r_state;
        state_t      w_state_nxt;
        logic [31:0] r_cnt;
        logic [31:0] w_cnt_nxt;
        logic        r_long_flag;
        logic        w_long_flag_nxt;
        logic        r_level;
        logic        w_level_nxt;
        logic        r_press;
        logic        w_press_nxt;
        logic        r_release;
        logic        w_release_nxt;
        logic        r_long_pls;
        logic        w_long_pls_nxt;
        logic        r_step;
        logic        w_step_nxt;
        logic        w_p;

        assign w_p = w_pressed[g];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state     <= IDLE;
                r_cnt       <= '0;
                r_long_flag <= 1'b0;
                r_level     <= 1'b0;
                r_press     <= 1'b0;
                r_release   <= 1'b0;
                r_long_pls  <= 1'b0;
                r_step      <= 1'b0;
            end else begin
                r_state     <= w_state_nxt;
                r_cnt       <= w_cnt_nxt;
                r_long_flag <= w_long_flag_nxt;
                r_level     <= w_level_nxt;
                r_press     <= w_press_nxt;
                r_release   <= w_release_nxt;
                r_long_pls  <= w_long_pls_nxt;
                r_step      <= w_step_nxt;
            end
        end

        always_comb begin
            // NOTE: every output gets a default first, so no path can infer a latch.
            w_state_nxt     = r_state;
            w_cnt_nxt       = r_cnt + 32'd1;
            w_long_flag_nxt = r_long_flag;
            w_level_nxt     = r_level;
            w_press_nxt     = 1'b0;
            w_release_nxt   = 1'b0;
            w_long_pls_nxt  = 1'b0;
            w_step_nxt      = 1'b0;

            unique case (r_state)
                IDLE: begin
                    w_cnt_nxt = '0;
                    if (w_p) begin
                        w_state_nxt = DEB_PRESS;
                    end
                end
                DEB_PRESS: begin
                    if (!w_p) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == DEB_LAST) begin
                        w_state_nxt = HELD;
                        w_cnt_nxt   = '0;
                        w_level_nxt = 1'b1;
                        w_press_nxt = 1'b1;
                        w_step_nxt  = 1'b1;
                    end
                end
                HELD: begin
                    if (!w_p) begin
                        w_state_nxt     = DEB_REL;
                        w_cnt_nxt       = '0;
                        w_long_flag_nxt = 1'b0;
                    end else if (r_cnt == LONG_LAST) begin
                        w_state_nxt    = LONG;
                        w_cnt_nxt      = '0;
                        w_long_pls_nxt = 1'b1;
                        w_step_nxt     = 1'b1;
                    end
                end
                LONG: begin
                    if (!w_p) begin
                        w_state_nxt     = DEB_REL;
                        w_cnt_nxt       = '0;
                        w_long_flag_nxt = 1'b1;
                    end else if (r_cnt == REP_LAST) begin
                        w_cnt_nxt  = '0;
                        w_step_nxt = 1'b1;
                    end
                end
                DEB_REL: begin
                    // A bounce back to pressed resumes the hold with a fresh timer.
                    if (w_p) begin
                        w_state_nxt = r_long_flag ? LONG : HELD;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == DEB_LAST) begin
                        w_state_nxt   = IDLE;
                        w_cnt_nxt     = '0;
                        w_level_nxt   = 1'b0;
                        w_release_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        assign o_level[g]   = r_level;
        assign o_press[g]   = r_press;
        assign o_release[g] = r_release;
        assign o_long[g]    = r_long_pls;
        assign o_step[g]    = r_step;
    end

endmodule

// File: tb/tb_sw_conditioner.sv
// Self-checking bench for sw_conditioner: directed timing tables, reset
// sequences and randomized switch activity against an edge-timestamp model.
module tb_sw_conditioner;

    localparam int NUM_SW = 4;
    localparam int DEB    = 4;
    localparam int LONGC  = 20;
    localparam int REP    = 8;

    logic              clk;
    logic              rst_n;
    logic [NUM_SW-1:0] i_sw;
    logic [NUM_SW-1:0] o_level;
    logic [NUM_SW-1:0] o_press;
    logic [NUM_SW-1:0] o_release;
    logic [NUM_SW-1:0] o_long;
    logic [NUM_SW-1:0] o_step;

    sw_conditioner #(
        .NUM_SW       (NUM_SW),
        .DEB_CYCLES   (DEB),
        .LONG_CYCLES  (LONGC),
        .REPEAT_CYCLES(REP),
        .ACTIVE_LOW   (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_sw     (i_sw),
        .o_level  (o_level),
        .o_press  (o_press),
        .o_release(o_release),
        .o_long   (o_long),
        .o_step   (o_step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the pressed level reaching the channel logic is the raw
    // level two edges earlier; decisions use run lengths and edge timestamps.
    logic [NUM_SW-1:0] m_s1, m_s2;
    logic [NUM_SW-1:0] m_lv, m_pr, m_rl, m_lg, m_st;
    bit  m_long_done [NUM_SW];
    bit  m_run_val   [NUM_SW];
    int  m_run_len   [NUM_SW];
    int  m_run_start [NUM_SW];
    int  m_accept    [NUM_SW];
    int  m_long_at   [NUM_SW];
    int  m_edge = 0;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0;
        m_lv = '0; m_pr = '0; m_rl = '0; m_lg = '0; m_st = '0;
        for (int ch = 0; ch < NUM_SW; ch++) begin
            m_long_done[ch] = 1'b0;
            m_run_val[ch]   = 1'b0;
            m_run_len[ch]   = 0;
            m_run_start[ch] = m_edge;
            m_accept[ch]    = 0;
            m_long_at[ch]   = 0;
        end
    endtask

    task automatic model_edge(input logic [NUM_SW-1:0] pressed);
        int anchor;
        bit p;
        m_edge++;
        m_pr = '0; m_rl = '0; m_lg = '0; m_st = '0;
        for (int ch = 0; ch < NUM_SW; ch++) begin
            p = m_s2[ch];
            if (p == m_run_val[ch]) begin
                m_run_len[ch]++;
            end else begin
                m_run_val[ch]   = p;
                m_run_len[ch]   = 1;
                m_run_start[ch] = m_edge;
            end
            if (!m_lv[ch] && p && m_run_len[ch] == DEB + 1) begin
                m_lv[ch] = 1'b1; m_pr[ch] = 1'b1; m_st[ch] = 1'b1;
                m_accept[ch] = m_edge; m_long_done[ch] = 1'b0;
            end else if (m_lv[ch] && !p && m_run_len[ch] == DEB + 1) begin
                m_lv[ch] = 1'b0; m_rl[ch] = 1'b1;
            end else if (m_lv[ch] && p) begin
                if (!m_long_done[ch]) begin
                    anchor = imax(m_accept[ch], m_run_start[ch]);
                    if (m_edge - anchor == LONGC) begin
                        m_lg[ch] = 1'b1; m_st[ch] = 1'b1;
                        m_long_done[ch] = 1'b1; m_long_at[ch] = m_edge;
                    end
                end else begin
                    anchor = imax(m_long_at[ch], m_run_start[ch]);
                    if (m_edge > anchor && (m_edge - anchor) % REP == 0) m_st[ch] = 1'b1;
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = pressed;
    endtask

    // Per-edge capture of {level,press,release,long,step} for the directed tables.
    logic [4:0] hist [256][NUM_SW];
    int rec_idx = 0;

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic [NUM_SW-1:0] pressed);
        i_sw = ~pressed;
        @(posedge clk);
        model_edge(pressed);
        #1;
        check("model", {12'd0, o_level, o_press, o_release, o_long, o_step},
              {12'd0, m_lv, m_pr, m_rl, m_lg, m_st});
        if (rec_idx < 256) begin
            for (int ch = 0; ch < NUM_SW; ch++)
                hist[rec_idx][ch] = {o_level[ch], o_press[ch], o_release[ch], o_long[ch], o_step[ch]};
            rec_idx++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_async", {12'd0, o_level, o_press, o_release, o_long, o_step}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        int         scen;
        string      name;
        int         cyc;
        int         ch;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input int s, input string n, input int c, input int ch, input logic [4:0] e);
        vec_t v;
        v.scen = s; v.name = n; v.cyc = c; v.ch = ch; v.exp = e;
        vecs.push_back(v);
    endtask

    function automatic logic [NUM_SW-1:0] stim_of(input int id, input int j);
        case (id)
            1: return (j < 15) ? 4'b0001 : 4'b0000;
            2: return (j < 25 && (j % 5) < 3) ? 4'b0010 : 4'b0000;
            3: return (j < 60 || (j >= 62 && j < 90)) ? 4'b0100 : 4'b0000;
            4: return (j < 10) ? 4'b1001 : 4'b0000;
            5: return (j < 12) ? 4'b0001 : 4'b0000;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic int len_of(input int id);
        case (id)
            1: return 35;
            2: return 45;
            3: return 110;
            4: return 30;
            default: return 32;
        endcase
    endfunction

    task automatic run_scen(input int id);
        rec_idx = 0;
        for (int j = 0; j < len_of(id); j++) step(stim_of(id, j));
    endtask

    task automatic check_table(input int id);
        foreach (vecs[i])
            if (vecs[i].scen == id)
                check(vecs[i].name, {27'd0, hist[vecs[i].cyc][vecs[i].ch]}, {27'd0, vecs[i].exp});
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step('0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NUM_SW-1:0] rnd_p;
        int seg_left [NUM_SW];
        int bad;

        // Expected encoding: {level, press, release, long, step}
        add_vec(1, "clean_pre",     5, 0, 5'b00000);
        add_vec(1, "clean_press",   6, 0, 5'b11001);
        add_vec(1, "clean_hold",    7, 0, 5'b10000);
        add_vec(1, "clean_ch1",     6, 1, 5'b00000);
        add_vec(1, "clean_ch3",     6, 3, 5'b00000);
        add_vec(1, "clean_prerel", 20, 0, 5'b10000);
        add_vec(1, "clean_rel",    21, 0, 5'b00100);
        add_vec(1, "clean_idle",   22, 0, 5'b00000);
        add_vec(3, "long_press",    6, 2, 5'b11001);
        add_vec(3, "long_before",  25, 2, 5'b10000);
        add_vec(3, "long_fire",    26, 2, 5'b10011);
        add_vec(3, "rep_gap",      33, 2, 5'b10000);
        add_vec(3, "rep_34",       34, 2, 5'b10001);
        add_vec(3, "rep_42",       42, 2, 5'b10001);
        add_vec(3, "rep_50",       50, 2, 5'b10001);
        add_vec(3, "rep_58",       58, 2, 5'b10001);
        add_vec(3, "glitch_level", 63, 2, 5'b10000);
        add_vec(3, "glitch_back",  64, 2, 5'b10000);
        add_vec(3, "glitch_nold",  66, 2, 5'b10000);
        add_vec(3, "glitch_rep",   72, 2, 5'b10001);
        add_vec(3, "rep_80",       80, 2, 5'b10001);
        add_vec(3, "rep_88",       88, 2, 5'b10001);
        add_vec(3, "long_prerel",  95, 2, 5'b10000);
        add_vec(3, "long_rel",     96, 2, 5'b00100);
        add_vec(3, "long_idle",    97, 2, 5'b00000);
        add_vec(4, "sim_pre0",      5, 0, 5'b00000);
        add_vec(4, "sim_pre3",      5, 3, 5'b00000);
        add_vec(4, "sim_press0",    6, 0, 5'b11001);
        add_vec(4, "sim_press3",    6, 3, 5'b11001);
        add_vec(4, "sim_rel0",     16, 0, 5'b00100);
        add_vec(4, "sim_rel3",     16, 3, 5'b00100);
        add_vec(5, "rst_pre",       5, 0, 5'b00000);
        add_vec(5, "rst_press",     6, 0, 5'b11001);
        add_vec(5, "rst_hold",      7, 0, 5'b10000);

        rst_n = 1'b0;
        i_sw  = '1;
        model_reset();
        #23;
        check("reset_state", {12'd0, o_level, o_press, o_release, o_long, o_step}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(10);

        run_scen(1); check_table(1); idle(10);

        run_scen(2);
        bad = 0;
        for (int j = 0; j < len_of(2); j++)
            for (int ch = 0; ch < NUM_SW; ch++)
                if (hist[j][ch][3:0] != 4'b0000 || (ch == 1 && hist[j][ch][4])) bad++;
        check("bounce_quiet", bad, 0);
        idle(10);

        run_scen(3); check_table(3); idle(10);
        run_scen(4); check_table(4); idle(10);

        // Reset while channel 0 is held, switch still pressed at release.
        for (int j = 0; j < 12; j++) step(4'b0001);
        check("rst_pre_level", {31'd0, o_level[0]}, 32'd1);
        do_reset();
        run_scen(5); check_table(5); idle(10);

        rnd_p = '0;
        for (int ch = 0; ch < NUM_SW; ch++) seg_left[ch] = int'($urandom_range(1, 10));
        for (int c = 0; c < 2400; c++) begin
            for (int ch = 0; ch < NUM_SW; ch++) begin
                if (seg_left[ch] == 0) begin
                    rnd_p[ch] = ~rnd_p[ch];
                    seg_left[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 70))
                                                               : int'($urandom_range(1, 7));
                end
                seg_left[ch]--;
            end
            if (c == 1200) do_reset();
            step(rnd_p);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
